// File: rtl/i2s_pkg.sv
// Shared I2S audio-path types: default sample width, sample type and FIFO playout state.
package i2s_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array FIFO storage with push/pop arbitration and an occupancy counter.
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push_req,
    input  logic                     i_pop_req,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data_c,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_push_c,
    output logic                     o_pop_c,
    output logic                     o_overflow_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_empty;
    logic             w_full;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign o_pop_c      = i_pop_req && !w_empty;
    assign o_push_c     = i_push_req && (!w_full || o_pop_c);
    assign o_overflow_c = i_push_req && w_full && !o_pop_c;
    assign o_rd_data_c  = r_mem[r_rd];
    assign o_level      = r_level;

    always_ff @(posedge i_clk) begin
        if (o_push_c) begin
            r_mem[r_wr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (o_push_c) begin
                r_wr <= r_wr + AW'(1);
            end
            if (o_pop_c) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({o_push_c, o_pop_c})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_sample_fifo.sv
// Frame-aligned sample FIFO between DSP and the I2S transmitter; primes before playout.
// Build option UNDERFLOW_HOLD_EN: repeat the last wet sample on underflow instead of muting.
module i2s_tx_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PRIME = 4
) (
    input  logic                     sclk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         sample_i,
    input  logic                     sampleValid_i,
    input  logic [WIDTH-1:0]         dryChan_i,
    input  logic                     ws_i,
    output logic [WIDTH-1:0]         leftChan_o,
    output logic [WIDTH-1:0]         rightChan_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic                     errSticky_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    fifo_state_t      r_state;
    fifo_state_t      w_state_next;
    logic             r_ws_prev;
    logic             w_frame_start;
    logic             w_run;
    logic             w_pop_req;
    logic             w_push;
    logic             w_pop;
    logic             w_overflow;
    logic             w_underflow;
    logic [WIDTH-1:0] w_rd_data;
    logic [LW-1:0]    w_level;
    logic [LW-1:0]    w_level_next;

    assign w_frame_start = r_ws_prev && !ws_i;
    assign w_run         = (r_state == i2s_pkg::RUN);
    assign w_pop_req     = w_run && w_frame_start;
    assign w_underflow   = w_pop_req && !w_pop;
    assign level_o       = w_level;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk        (sclk_i),
        .i_rst        (rst_i),
        .i_push_req   (sampleValid_i),
        .i_pop_req    (w_pop_req),
        .i_wr_data    (sample_i),
        .o_rd_data_c  (w_rd_data),
        .o_level      (w_level),
        .o_push_c     (w_push),
        .o_pop_c      (w_pop),
        .o_overflow_c (w_overflow)
    );

    always_comb begin
        w_level_next = w_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = w_level + LW'(1);
            2'b01:   w_level_next = w_level - LW'(1);
            default: w_level_next = w_level;
        endcase
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_state <= i2s_pkg::PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priming is checked every cycle against the post-push occupancy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            i2s_pkg::PRIME: begin
                if (w_level_next >= LW'(PRIME)) begin
                    w_state_next = i2s_pkg::RUN;
                end
            end
            i2s_pkg::RUN: begin
                if (w_underflow) begin
                    w_state_next = i2s_pkg::PRIME;
                end
            end
            default: w_state_next = i2s_pkg::PRIME;
        endcase
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_ws_prev   <= 1'b1;
            leftChan_o  <= '0;
            rightChan_o <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            errSticky_o <= 1'b0;
        end else begin
            r_ws_prev   <= ws_i;
            overflow_o  <= w_overflow;
            underflow_o <= w_underflow;
            errSticky_o <= errSticky_o || w_overflow || w_underflow;
            if (w_frame_start) begin
                leftChan_o <= dryChan_i;
                if (!w_run) begin
                    rightChan_o <= '0;
                end else if (w_pop) begin
                    rightChan_o <= w_rd_data;
                end else begin
`ifdef UNDERFLOW_HOLD_EN
                    rightChan_o <= rightChan_o;
`else
                    rightChan_o <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sample_fifo.sv
// Self-checking bench for i2s_tx_sample_fifo: directed scenarios plus random traffic vs. a queue model.
module tb_i2s_tx_sample_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PRIME = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef UNDERFLOW_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic             sclk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sample;
    logic             valid;
    logic [WIDTH-1:0] dry;
    logic             ws;
    logic [WIDTH-1:0] left_o;
    logic [WIDTH-1:0] right_o;
    logic [LW-1:0]    level_o;
    logic             ovf_o;
    logic             udf_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_run;
    bit               m_ws_prev;
    logic [WIDTH-1:0] m_left;
    logic [WIDTH-1:0] m_right;
    bit               m_ovf;
    bit               m_udf;
    bit               m_err;

    i2s_tx_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PRIME (PRIME)
    ) dut (
        .sclk_i        (sclk),
        .rst_i         (rst),
        .sample_i      (sample),
        .sampleValid_i (valid),
        .dryChan_i     (dry),
        .ws_i          (ws),
        .leftChan_o    (left_o),
        .rightChan_o   (right_o),
        .level_o       (level_o),
        .overflow_o    (ovf_o),
        .underflow_o   (udf_o),
        .errSticky_o   (err_o)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Predict the effect of the upcoming edge from the currently applied inputs.
    task automatic model_step();
        bit fs, pop, udf, ovf;
        if (rst) begin
            q.delete();
            m_run = 1'b0; m_ws_prev = 1'b1;
            m_left = '0; m_right = '0;
            m_ovf = 1'b0; m_udf = 1'b0; m_err = 1'b0;
            return;
        end
        fs  = m_ws_prev && !ws;
        pop = m_run && fs && (q.size() > 0);
        udf = m_run && fs && (q.size() == 0);
        ovf = valid && (q.size() == DEPTH) && !pop;
        if (fs) begin
            m_left = dry;
            if (!m_run)   m_right = '0;
            else if (pop) m_right = q[0];
            else if (!HOLD) m_right = '0;
        end
        if (pop) void'(q.pop_front());
        if (valid && !ovf) q.push_back(sample);
        if (!m_run) m_run = (q.size() >= PRIME);
        else if (udf) m_run = 1'b0;
        m_ovf = ovf;
        m_udf = udf;
        m_err = m_err || ovf || udf;
        m_ws_prev = ws;
    endtask

    task automatic compare_all();
        chk("level", 32'(level_o), 32'(q.size()));
        chk("left", 32'(left_o), 32'(m_left));
        chk("right", 32'(right_o), 32'(m_right));
        chk("overflow", 32'(ovf_o), 32'(m_ovf));
        chk("underflow", 32'(udf_o), 32'(m_udf));
        chk("errSticky", 32'(err_o), 32'(m_err));
    endtask

    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] s, input bit w);
        rst    = r;
        valid  = v;
        sample = s;
        ws     = w;
        dry    = WIDTH'($urandom);
        model_step();
        @(posedge sclk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic push(input logic [WIDTH-1:0] s);
        step(1'b0, 1'b1, s, 1'b1);
    endtask

    // One frame: a ws=1 cycle followed by the ws 1->0 frame-start cycle.
    task automatic frame(input bit v, input logic [WIDTH-1:0] s);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, v, s, 1'b0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sample = '0; dry = '0; ws = 1'b1;
        #2;

        // Reset priming
        do_reset();
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_right", 32'(right_o), 32'd0);
        for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        frame(1'b0, '0);
        chk("prime_first_right", 32'(right_o), 32'h0001);
        chk("prime_first_level", 32'(level_o), 32'd3);

        // Prime gating
        do_reset();
        for (int i = 1; i <= 3; i++) push(WIDTH'(i));
        for (int i = 0; i < 3; i++) frame(1'b0, '0);
        chk("gate_right", 32'(right_o), 32'd0);
        chk("gate_level", 32'(level_o), 32'd3);
        chk("gate_udf", 32'(err_o), 32'd0);

        // Overflow
        do_reset();
        for (int i = 0; i < 8; i++) push(WIDTH'(16 + i));
        push(16'h00FF);
        chk("ovf_pulse", 32'(ovf_o), 32'd1);
        chk("ovf_level", 32'(level_o), 32'd8);
        chk("ovf_sticky", 32'(err_o), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("ovf_one_cycle", 32'(ovf_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            frame(1'b0, '0);
            chk("ovf_drain", 32'(right_o), 32'(16 + i));
        end

        // Full with simultaneous push and pop, then underflow
        do_reset();
        for (int i = 0; i < 8; i++) push(WIDTH'(32 + i));
        frame(1'b1, 16'h0AAA);
        chk("full_pp_ovf", 32'(ovf_o), 32'd0);
        chk("full_pp_level", 32'(level_o), 32'd8);
        chk("full_pp_head", 32'(right_o), 32'h0020);
        for (int i = 1; i < 8; i++) begin
            frame(1'b0, '0);
            chk("full_pp_old", 32'(right_o), 32'(32 + i));
        end
        frame(1'b0, '0);
        chk("full_pp_new", 32'(right_o), 32'h0AAA);
        frame(1'b1, 16'h1234);
        chk("udf_pulse", 32'(udf_o), 32'd1);
        chk("udf_right", 32'(right_o), HOLD ? 32'h0AAA : 32'd0);
        chk("udf_push_kept", 32'(level_o), 32'd1);
        frame(1'b0, '0);
        chk("udf_back_to_prime", 32'(right_o), 32'd0);

        // Reset mid-run
        do_reset();
        for (int i = 0; i < 5; i++) push(WIDTH'(64 + i));
        chk("mid_level", 32'(level_o), 32'd5);
        do_reset();
        chk("mid_rst_level", 32'(level_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        frame(1'b0, '0);
        chk("mid_no_pop", 32'(right_o), 32'd0);
        chk("mid_no_udf", 32'(udf_o), 32'd0);

        // Random traffic with varying push density and frame lengths
        do_reset();
        for (int phase = 0; phase < 4; phase++) begin
            int unsigned push_pct = 10 + 15 * phase;
            for (int f = 0; f < 150; f++) begin
                int unsigned hi = $urandom_range(1, 4);
                int unsigned lo = $urandom_range(1, 4);
                for (int c = 0; c < int'(hi + lo); c++) begin
                    bit r = ($urandom_range(0, 999) == 0);
                    step(r, ($urandom_range(0, 99) < push_pct), WIDTH'($urandom), (c < int'(hi)));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_sample_fifo.md
Name: i2s_tx_sample_fifo

Overview:
- Buffers processed samples from the DSP stage and releases them to the I2S transmitter one per frame, aligned to the word-select frame boundary.
- Sits directly downstream of DSP and upstream of I2Stx.
- Absorbs jitter between the DSP output strobe and the I2S frame timing.
- Primes to a fill threshold before playout; reports overflow and underflow.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO entries; power of two, >= 4.
- PRIME, 4, occupancy required before playout starts; 1 <= PRIME <= DEPTH.

Ports:
- sclk_i  in  1  I2S bit clock; the only clock.
- rst_i  in  1  synchronous reset, active-high.
- sample_i  in  WIDTH  DSP output sample (signed two's complement).
- sampleValid_i  in  1  one-cycle push strobe for sample_i.
- dryChan_i  in  WIDTH  unprocessed sample for the opposite channel.
- ws_i  in  1  word select; 0 = left, 1 = right.
- leftChan_o  out  WIDTH  dry sample to the transmitter.
- rightChan_o  out  WIDTH  wet sample to the transmitter.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  one-cycle pulse: push dropped.
- underflow_o  out  1  one-cycle pulse: pop on empty.
- errSticky_o  out  1  set on any overflow or underflow; cleared only by reset.

Behaviour:
- Reset (sync, rst_i=1 at a rising edge):
  - FIFO emptied: pointers = 0, level_o = 0.
  - State = PRIME.
  - All outputs = 0. wsPrev = 1, so no false frame start on the first cycle after reset.
  - Reset mid-operation discards buffered samples; no outputs pulse.
- frameStart is combinational: wsPrev==1 && ws_i==0. wsPrev registers ws_i every cycle.
- Push:
  - Occurs when sampleValid_i=1 and (level < DEPTH, or a pop happens in the same cycle).
  - Writes mem[wr], wr increments mod DEPTH.
  - sampleValid_i=1 while full with no pop: sample dropped, overflow_o pulses, contents unchanged.
- State PRIME:
  - Pushes accepted; no pops.
  - On frameStart: leftChan_o <= dryChan_i and rightChan_o <= 0.
  - Transition to RUN when level (after this cycle's push) >= PRIME. Evaluated every cycle, not just at frameStart.
- State RUN:
  - On frameStart with level > 0: pop, giving rightChan_o <= mem[rd], leftChan_o <= dryChan_i, rd increments mod DEPTH.
  - On frameStart with level == 0 (push in the same cycle does not count):
    - underflow_o pulses; state returns to PRIME.
    - rightChan_o behaviour per the Optional Feature.
    - leftChan_o still updates.
- Latency: outputs update at the rising edge that ends the frameStart cycle. They hold for the whole frame, i.e. stable before I2Stx shifts the left word.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - Pop reads the old head.
  - On a full FIFO this is accepted with no overflow.
- Pointers wrap modulo DEPTH. level is a separate counter: +1 push only, −1 pop only, unchanged for both or neither.
- errSticky_o is set on the same edge as either pulse.

Optional Feature:
- Macro UNDERFLOW_HOLD_EN.
- Defined: on underflow, rightChan_o holds its previous value (last-sample repeat).
- Undefined: on underflow, rightChan_o <= 0 (mute).
- PRIME-state output is 0 in both builds.

Decomposition:
- Shared package i2s_pkg:
  - Sample typedef sample_t = logic signed [WIDTH-1:0].
  - State enum fifo_state_t {PRIME, RUN}.
  - Default WIDTH constant, shared with I2Srx, I2Stx and DSP.
- One sub-module, sync_fifo_mem: dual-pointer register-array storage with the push/pop/level logic.
- The top-level block keeps the frame-edge detect, FSM and output registers.

Test Plan:
- Reset priming: reset, push 4 samples 0x0001..0x0004, then toggle ws_i 1->0 → state RUN; first frameStart gives rightChan_o=0x0001 one edge later; level_o 4->3.
- Prime gating: push 3 samples, run 3 frames → rightChan_o stays 0, level_o stays 3, no underflow.
- Overflow: fill 8 (0x0010..0x0017), push 0x00FF with no frameStart → overflow_o one cycle, errSticky_o=1, level_o=8. Subsequent pops yield 0x0010..0x0017 with 0x00FF absent.
- Full + simultaneous push/pop: level 8, push 0x0AAA in the frameStart cycle → no overflow, level_o stays 8, pop returns the old head, 0x0AAA emerges 8 frames later.
- Underflow: in RUN, drain to empty, next frameStart → underflow_o pulse, state PRIME, rightChan_o=last sample (HOLD_EN) or 0 (undefined). A push of 0x1234 in the same cycle is buffered, not output.
- Reset mid-run: level 5, assert rst_i one cycle → level_o=0, outputs 0, errSticky_o=0; next frameStart yields no pop.
